pkt_rd_sequencer: RTL and testbench
===================================

// Module: pkt_rd_sequencer
// PURPOSE
//  Multi-channel packet read sequencer for the ADC capture path. On a capture start it reads the
//  capture memory window-by-window and emits fixed-length packets per enabled channel, with a
//  programmable gap between packets. It raises a done pulse per pass and rearms on capture_again.
//  Sits between the capture memory and the pad-side data/valid serializer in digital_top.
// PARAMETERS
//  DATA_W    18   sample width per channel
//  ADDR_W    13   capture memory address width; DEPTH = 2**ADDR_W words per channel
//  NUM_CH    2    channels stored side by side in one memory word
//  BASE_LEN  216  packet length for pkt_len_sel=0; length = BASE_LEN << pkt_len_sel
//  GAP_W     4    width of pkt_gap
// PORTS
//  clk            in   1                 system clock
//  rstn           in   1                 asynchronous active-low reset
//  cfg_en         in   1                 block enable; 0 = synchronous abort to IDLE
//  capture_start  in   1                 start pulse, level-to-edge detected internally
//  capture_again  in   1                 re-read pulse, accepted only in DONE
//  pkt_len_sel    in   2                 00=216, 01=432, 10=864, 11=1728 words (BASE_LEN default)
//  pkt_gap        in   GAP_W             idle cycles between packets; 0 = back-to-back
//  ch_mask        in   NUM_CH            enabled channels
//  mem_rd_en      out  1                 memory read strobe
//  mem_rd_addr    out  ADDR_W            memory read address
//  mem_rd_data    in   NUM_CH*DATA_W     read data, valid 1 cycle after mem_rd_en; ch0 in LSBs
//  out_data       out  DATA_W            packet sample
//  out_valid      out  1                 out_data valid
//  out_sop/out_eop out 1 each            first / last word of a packet, qualified by out_valid
//  out_ch         out  max(1,$clog2(NUM_CH))  channel of the current packet
//  busy           out  1                 high outside IDLE and DONE
//  rd_done        out  1                 1-cycle pulse when a pass completes
//  cfg_err        out  1                 1-cycle pulse when a start is rejected with ch_mask==0
// BEHAVIOUR
//  - Reset: every output is 0. FSM=IDLE, address/counters=0.
//  - pkt_len_sel, pkt_gap and ch_mask are sampled on an accepted start or again.
//    They stay frozen until the pass ends.
//  - FSM states:
//    IDLE -start rise & cfg_en & |ch_mask-> PKT.
//    PKT: issues len reads at consecutive addrs base..base+len-1, one per cycle, for the current channel.
//      After the last read: -> GAP if pkt_gap!=0, else straight to the next packet.
//    GAP: counts pkt_gap idle cycles with no reads, then -> PKT.
//    Packet order: enabled channels in ascending index for the same window. Then base += len.
//    The pass ends when base+len > DEPTH. Residual words are never read.
//      On pass end -> DONE, with rd_done pulsed in the cycle the last out_eop is emitted.
//    DONE: -again rise-> PKT with base=0. -start rise-> PKT with base=0.
//      Config is resampled in both cases.
//  - Output timing: out_valid/out_data/out_sop/out_eop/out_ch are registered.
//    They equal the read issued 1 cycle earlier. Latency is start edge -> first mem_rd_en = 1 cycle,
//    and -> first out_valid = 2 cycles.
//  - mem_rd_addr never exceeds DEPTH-1 and never wraps within a pass.
//  - Start while busy is ignored. Again outside DONE is ignored.
//    Start and again in the same cycle in DONE count as one restart.
//  - Start with ch_mask==0: no transition, cfg_err pulses.
//  - cfg_en=0 in any state: next cycle FSM=IDLE, outputs 0, and any in-flight read data is discarded.
//    No rd_done is issued.
//  - Async reset mid-packet: everything clears immediately. No partial eop is emitted.
//  - With a single-word window (len=1, test-only parameterisation) sop and eop assert together.
// TESTING
//  T1 defaults, sel=01, gap=4, mask=11, start pulse ->
//     packets ch0 addr0-431, 4 idle, ch1 addr0-431, 4 idle, ch0 addr432...;
//     18 windows (36 packets); rd_done once; last addr 7775.
//  T2 after T1 DONE, again pulse ->
//     identical second pass from addr 0; then a third again also accepted.
//     Start during the pass is ignored.
//  T3 sel=11, gap=0, mask=10 ->
//     only ch1 packets, back-to-back (eop then sop on the next cycle), 4 windows, last addr 6911.
//  T4 mask=00, start -> cfg_err=1 for 1 cycle, busy stays 0, no mem_rd_en.
//  T5 cfg_en dropped mid-packet at word 100 ->
//     IDLE next cycle, out_valid=0, no rd_done; a re-enable plus start restarts from addr 0.
//  T6 rstn asserted mid-GAP -> all outputs 0 asynchronously; a start after release behaves as T1.

Source files
------------

// File: rtl/pkt_rd_sequencer.sv
// Multi-channel packet read sequencer: walks the capture memory window by window and
// emits one fixed-length packet per enabled channel, with a programmable gap between packets.
module pkt_rd_sequencer #(
  parameter int DATA_W   = 18,
  parameter int ADDR_W   = 13,
  parameter int NUM_CH   = 2,
  parameter int BASE_LEN = 216,
  parameter int GAP_W    = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cfg_en,
  input  logic                     capture_start,
  input  logic                     capture_again,
  input  logic [1:0]               pkt_len_sel,
  input  logic [GAP_W-1:0]         pkt_gap,
  input  logic [NUM_CH-1:0]        ch_mask,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [NUM_CH*DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy,
  output logic                     rd_done,
  output logic                     cfg_err,
  output logic [1:0]               dbg_state
);

  localparam int CNT_W = ADDR_W + 2;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_GAP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    word_q, word_d, len_q, len_d;
  logic [GAP_W-1:0]    gap_q, gap_d, gapcfg_q, gapcfg_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     ch_q, ch_d, och_q, och_d;
  logic                start_q, again_q;
  logic                ov_q, ov_d, sop_q, sop_d, eop_q, eop_d, done_q, done_d, err_q, err_d;

  logic                start_rise, again_rise, launch, last_word, pass_end, nxt_found;
  logic [CH_W-1:0]     nxt_ch;
  logic [CNT_W-1:0]    win_next, len_in;

  function automatic logic [CH_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = CH_W'(i);
    end
    return r;
  endfunction

  assign start_rise = capture_start & ~start_q;
  assign again_rise = capture_again & ~again_q;
  assign len_in     = CNT_W'(BASE_LEN) << pkt_len_sel;
  assign last_word  = (word_q == len_q - 1'b1);
  assign win_next   = CNT_W'(base_q) + len_q;
  // The pass ends once the following window would run past the top of memory.
  assign pass_end   = (win_next + len_q) > CNT_W'(DEPTH);
  assign launch     = cfg_en && (((state_q == S_IDLE) && start_rise) ||
                                 ((state_q == S_DONE) && (start_rise || again_rise)));

  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = ch_q;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    word_d   = word_q;
    len_d    = len_q;
    gap_d    = gap_q;
    gapcfg_d = gapcfg_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    ov_d     = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    och_d    = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_PKT: begin
        ov_d  = 1'b1;
        sop_d = (word_q == '0);
        eop_d = last_word;
        och_d = ch_q;
        if (!last_word) begin
          word_d = word_q + 1'b1;
        end else begin
          word_d = '0;
          if (nxt_found) begin
            ch_d = nxt_ch;
          end else if (!pass_end) begin
            base_d = ADDR_W'(win_next);
            ch_d   = first_ch(mask_q);
          end
          if (!nxt_found && pass_end) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (gapcfg_q != '0) begin
            state_d = S_GAP;
            gap_d   = gapcfg_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_PKT;
        else             gap_d   = gap_q - 1'b1;
      end
      default: ;
    endcase
    if (launch) begin
      if (ch_mask == '0) begin
        err_d = 1'b1;
      end else begin
        state_d  = S_PKT;
        base_d   = '0;
        word_d   = '0;
        len_d    = len_in;
        gapcfg_d = pkt_gap;
        mask_d   = ch_mask;
        ch_d     = first_ch(ch_mask);
      end
    end
    // Disable wins over everything, including the read already in flight.
    if (!cfg_en) begin
      state_d = S_IDLE;
      base_d  = '0;
      word_d  = '0;
      gap_d   = '0;
      ch_d    = '0;
      ov_d    = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      och_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      word_q   <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      gapcfg_q <= '0;
      mask_q   <= '0;
      ch_q     <= '0;
      start_q  <= 1'b0;
      again_q  <= 1'b0;
      ov_q     <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      och_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      word_q   <= word_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      gapcfg_q <= gapcfg_d;
      mask_q   <= mask_d;
      ch_q     <= ch_d;
      start_q  <= capture_start;
      again_q  <= capture_again;
      ov_q     <= ov_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      och_q    <= och_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign mem_rd_en   = (state_q == S_PKT);
  assign mem_rd_addr = mem_rd_en ? ADDR_W'(CNT_W'(base_q) + word_q) : '0;
  assign out_valid   = ov_q;
  assign out_sop     = sop_q;
  assign out_eop     = eop_q;
  assign out_ch      = och_q;
  // Memory returns data one cycle after the strobe, aligned with the registered qualifiers.
  assign out_data    = ov_q ? mem_rd_data[int'(och_q)*DATA_W +: DATA_W] : '0;
  assign busy        = (state_q == S_PKT) || (state_q == S_GAP);
  assign rd_done     = done_q;
  assign cfg_err     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pkt_rd_sequencer.sv
// Directed bench for pkt_rd_sequencer: a per-cycle expected-output timeline built from the
// packet/window rules, checked against the DUT on every falling edge.
module tb_pkt_rd_sequencer;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 13;
  localparam int NUM_CH = 2;
  localparam int GAP_W  = 4;
  localparam int CH_W   = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     rstn, cfg_en, capture_start, capture_again;
  logic [1:0]               pkt_len_sel;
  logic [GAP_W-1:0]         pkt_gap;
  logic [NUM_CH-1:0]        ch_mask;
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_rd_addr;
  logic [NUM_CH*DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid, out_sop, out_eop, busy, rd_done, cfg_err;
  logic [CH_W-1:0]          out_ch;
  logic [1:0]               dbg_state;

  pkt_rd_sequencer dut (
    .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .capture_start(capture_start),
    .capture_again(capture_again), .pkt_len_sel(pkt_len_sel), .pkt_gap(pkt_gap),
    .ch_mask(ch_mask), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_ch(out_ch), .busy(busy),
    .rd_done(rd_done), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [DATA_W-1:0] pattern(int a, int c);
    return DATA_W'(a * 3 + c * 40000 + 11);
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) begin
      for (int c = 0; c < NUM_CH; c++) mem_rd_data[c*DATA_W +: DATA_W] <= pattern(int'(mem_rd_addr), c);
    end
  end

  // ---------------- scoreboard ----------------
  // One entry per falling edge: what the read side shows now; the output side shows the previous entry.
  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [CH_W-1:0]   ch;
    logic              sop;
    logic              eop;
    logic              last;
    logic              busy;
    logic              err;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  exp_t prev = '0;
  bit   flush_req = 1'b0;
  int   checks = 0, failures = 0;
  int   n_rd = 0, n_done = 0, n_sop = 0, n_err = 0, last_addr = -1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Builds the whole pass: windows of len words, enabled channels ascending, gap before every packet but the first.
  task automatic model_pass(int len, int gap, logic [NUM_CH-1:0] mask);
    exp_t e;
    exp_t t;
    bit   first;
    first = 1'b1;
    exp_q.push_back(EXP_W'(0));
    for (int base = 0; base + len <= DEPTH; base += len) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask[c]) begin
          if (!first) begin
            for (int g = 0; g < gap; g++) begin
              e = '0;
              e.busy = 1'b1;
              exp_q.push_back(EXP_W'(e));
            end
          end
          first = 1'b0;
          for (int w = 0; w < len; w++) begin
            e = '0;
            e.rd = 1'b1; e.busy = 1'b1; e.addr = ADDR_W'(base + w); e.ch = CH_W'(c);
            e.sop = (w == 0); e.eop = (w == len - 1);
            exp_q.push_back(EXP_W'(e));
          end
        end
      end
    end
    t = exp_t'(exp_q.pop_back());
    t.last = 1'b1;
    exp_q.push_back(EXP_W'(t));
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t p;
    logic [63:0] act_v, exp_v;
    e = '0;
    if (exp_q.size() > 0) e = exp_t'(exp_q.pop_front());
    p = prev;
    act_v = {25'd0, mem_rd_en, mem_rd_addr, busy, cfg_err, out_valid, out_sop, out_eop,
             out_ch, out_data, rd_done};
    exp_v = {25'd0, e.rd, (e.rd ? e.addr : ADDR_W'(0)), e.busy, e.err, p.rd, p.rd & p.sop,
             p.rd & p.eop, (p.rd ? p.ch : CH_W'(0)),
             (p.rd ? pattern(int'(p.addr), int'(p.ch)) : DATA_W'(0)), p.last};
    check("cycle{rd,addr,busy,err,vld,sop,eop,ch,data,done}", act_v, exp_v);
    if (mem_rd_en) begin
      n_rd++;
      last_addr = int'(mem_rd_addr);
    end
    if (out_valid && out_sop) n_sop++;
    if (rd_done) n_done++;
    if (cfg_err) n_err++;
    prev = e;
    if (flush_req) begin
      exp_q.delete();
      prev = '0;
      flush_req = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_rd = 0; n_done = 0; n_sop = 0; n_err = 0; last_addr = -1;
  endtask

  // Drives the trigger and loads the model; the caller releases it with release_trig().
  task automatic drive_trig(bit s, bit a, logic [1:0] sel, logic [GAP_W-1:0] gap,
                            logic [NUM_CH-1:0] mask);
    exp_t e;
    pkt_len_sel   = sel;
    pkt_gap       = gap;
    ch_mask       = mask;
    capture_start = s;
    capture_again = a;
    if (mask != '0) begin
      model_pass(216 << sel, int'(gap), mask);
    end else begin
      exp_q.push_back(EXP_W'(0));
      e = '0;
      e.err = 1'b1;
      exp_q.push_back(EXP_W'(e));
    end
  endtask

  task automatic release_trig();
    tick(1);
    capture_start = 1'b0;
    capture_again = 1'b0;
  endtask

  task automatic pulse_ignored(bit s, bit a);
    capture_start = s;
    capture_again = a;
    tick(1);
    capture_start = 1'b0;
    capture_again = 1'b0;
  endtask

  task automatic wait_drain(int budget, string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_drain_within_budget"}, exp_q.size(), 0);
    tick(2);
  endtask

  task automatic check_t1_pass(string name);
    check({name, "_reads"}, n_rd, 15552);
    check({name, "_done_pulses"}, n_done, 1);
    check({name, "_last_addr"}, last_addr, 7775);
    check({name, "_packets"}, n_sop, 36);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; cfg_en = 1'b0; capture_start = 1'b0; capture_again = 1'b0;
    pkt_len_sel = '0; pkt_gap = '0; ch_mask = '0;
    tick(3);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    rstn = 1'b1;
    cfg_en = 1'b1;
    tick(2);

    // T1: 432-word packets, 4-cycle gap, both channels
    clear_counts();
    drive_trig(1'b1, 1'b0, 2'b01, 4'd4, 2'b11);
    check("t1_model_timeline_len", exp_q.size(), 15693);
    release_trig();
    wait_drain(20000, "t1");
    check_t1_pass("t1");

    // T2: again restarts; start/again during the pass and config changes are ignored
    clear_counts();
    drive_trig(1'b0, 1'b1, 2'b01, 4'd4, 2'b11);
    release_trig();
    tick(1000);
    ch_mask = 2'b01; pkt_gap = 4'd0; pkt_len_sel = 2'b11;
    pulse_ignored(1'b1, 1'b0);
    tick(3);
    pulse_ignored(1'b0, 1'b1);
    wait_drain(20000, "t2a");
    check_t1_pass("t2a");
    clear_counts();
    drive_trig(1'b1, 1'b1, 2'b01, 4'd4, 2'b11);
    release_trig();
    wait_drain(20000, "t2b");
    check_t1_pass("t2b");

    // T3: 1728-word packets, no gap, channel 1 only
    clear_counts();
    drive_trig(1'b1, 1'b0, 2'b11, 4'd0, 2'b10);
    check("t3_model_timeline_len", exp_q.size(), 6913);
    release_trig();
    wait_drain(8000, "t3");
    check("t3_reads", n_rd, 6912);
    check("t3_last_addr", last_addr, 6911);
    check("t3_packets", n_sop, 4);
    check("t3_done_pulses", n_done, 1);

    // T4: empty channel mask is rejected
    clear_counts();
    drive_trig(1'b1, 1'b0, 2'b00, 4'd1, 2'b00);
    release_trig();
    tick(5);
    check("t4_cfg_err_pulses", n_err, 1);
    check("t4_reads", n_rd, 0);

    // T5: disable at word 100, then restart from address 0
    clear_counts();
    drive_trig(1'b1, 1'b0, 2'b11, 4'd1, 2'b01);
    release_trig();
    tick(100);
    cfg_en = 1'b0;
    flush_req = 1'b1;
    tick(3);
    check("t5_reads_before_abort", n_rd, 101);
    check("t5_no_done", n_done, 0);
    check("t5_idle_state", dbg_state, 0);
    cfg_en = 1'b1;
    tick(1);
    clear_counts();
    drive_trig(1'b1, 1'b0, 2'b00, 4'd2, 2'b01);
    release_trig();
    wait_drain(10000, "t5r");
    check("t5r_reads", n_rd, 7992);
    check("t5r_last_addr", last_addr, 7991);
    check("t5r_packets", n_sop, 37);

    // T6: async reset in the middle of a gap, then a fresh T1 pass
    clear_counts();
    drive_trig(1'b1, 1'b0, 2'b01, 4'd4, 2'b11);
    release_trig();
    tick(433);
    check("t6_in_gap_busy", busy, 1);
    check("t6_in_gap_no_read", mem_rd_en, 0);
    rstn = 1'b0;
    exp_q.delete();
    prev = '0;
    #1;
    check("t6_async_busy", busy, 0);
    tick(2);
    check("t6_no_done", n_done, 0);
    rstn = 1'b1;
    tick(2);
    clear_counts();
    drive_trig(1'b1, 1'b0, 2'b01, 4'd4, 2'b11);
    release_trig();
    wait_drain(20000, "t6");
    check_t1_pass("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
